// File: rtl/mac_lkup_arb.sv
// Round-robin arbiter that serialises per-port learn/lookup requests onto a
// single hashed MAC table with a fixed read latency.

module mac_lkup_arb_chk #(
    parameter int pNUM_PORTS = 4
) (
    input logic                  iclk,
    input logic                  irst_n,
    input logic [pNUM_PORTS-1:0] oack,
    input logic                  omem_wr_en,
    input logic                  obusy
);

    a_ack_onehot : assert property (@(posedge iclk) disable iff (!irst_n)
        $onehot0(oack))
        else $error("oack is not one-hot or zero");

    a_wr_in_busy : assert property (@(posedge iclk) disable iff (!irst_n)
        omem_wr_en |-> obusy)
        else $error("omem_wr_en asserted while not busy");

    a_ack_wr_excl : assert property (@(posedge iclk) disable iff (!irst_n)
        !(omem_wr_en && (oack != {pNUM_PORTS{1'b0}})))
        else $error("omem_wr_en and oack asserted together");

endmodule

module mac_lkup_arb #(
    parameter int pNUM_PORTS  = 4,
    parameter int pADDR_WIDTH = 14,
    parameter int pMEM_LAT    = 2,
    localparam int PW         = $clog2(pNUM_PORTS)
) (
    input  logic                              iclk,
    input  logic                              irst_n,
    input  logic [pNUM_PORTS-1:0]             ireq,
    input  logic [pNUM_PORTS*pADDR_WIDTH-1:0] isa_bus,
    input  logic [pNUM_PORTS*pADDR_WIDTH-1:0] ida_bus,
    input  logic                              iage_busy,
    input  logic [PW-1:0]                     imem_pnum,
    output logic                              omem_wr_en,
    output logic [PW-1:0]                     omem_pnum,
    output logic [pADDR_WIDTH-1:0]            omem_sa,
    output logic [pADDR_WIDTH-1:0]            omem_da,
    output logic [pNUM_PORTS-1:0]             oack,
    output logic [PW-1:0]                     oresp_pnum,
    output logic                              obusy
);

    localparam int CW = $clog2(pMEM_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // First requesting port at or after ptr, wrapping past the top port.
    function automatic logic [PW-1:0] rr_pick(
        input logic [pNUM_PORTS-1:0] req,
        input logic [PW-1:0]         ptr
    );
        logic        found;
        logic [PW-1:0] pick;
        int unsigned idx;
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < pNUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= pNUM_PORTS) begin
                idx = idx - pNUM_PORTS;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [pNUM_PORTS-1:0] port_onehot(input logic [PW-1:0] p);
        logic [pNUM_PORTS-1:0] v;
        v    = {pNUM_PORTS{1'b0}};
        v[p] = 1'b1;
        return v;
    endfunction

    state_t                  state_r;
    state_t                  next_state_s;
    logic [PW-1:0]           rr_ptr_r;
    logic [PW-1:0]           rr_ptr_next_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_next_s;
    logic                    wr_en_r;
    logic                    wr_en_next_s;
    logic [PW-1:0]           pnum_r;
    logic [PW-1:0]           pnum_next_s;
    logic [pADDR_WIDTH-1:0]  sa_r;
    logic [pADDR_WIDTH-1:0]  sa_next_s;
    logic [pADDR_WIDTH-1:0]  da_r;
    logic [pADDR_WIDTH-1:0]  da_next_s;
    logic [pNUM_PORTS-1:0]   ack_r;
    logic [pNUM_PORTS-1:0]   ack_next_s;
    logic [PW-1:0]           resp_pnum_r;
    logic [PW-1:0]           resp_pnum_next_s;
    logic                    busy_r;
    logic                    busy_next_s;
    logic                    req_go_s;
    logic                    last_wait_s;
    logic [PW-1:0]           pick_s;

    assign req_go_s    = (ireq != {pNUM_PORTS{1'b0}}) && !iage_busy;
    assign last_wait_s = (cnt_r == CW'(1));
    assign pick_s      = rr_pick(ireq, rr_ptr_r);

    // State register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_go_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (last_wait_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered below.
    always_comb begin
        cnt_next_s       = cnt_r;
        rr_ptr_next_s    = rr_ptr_r;
        pnum_next_s      = pnum_r;
        sa_next_s        = sa_r;
        da_next_s        = da_r;
        resp_pnum_next_s = {PW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (req_go_s) begin
                    pnum_next_s = pick_s;
                    sa_next_s   = isa_bus[int'(pick_s)*pADDR_WIDTH +: pADDR_WIDTH];
                    da_next_s   = ida_bus[int'(pick_s)*pADDR_WIDTH +: pADDR_WIDTH];
                end else begin
                    pnum_next_s = pnum_r;
                end
            end
            ST_ISSUE: cnt_next_s = CW'(pMEM_LAT);
            ST_WAIT: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_next_s = cnt_r - CW'(1);
                end else begin
                    cnt_next_s = cnt_r;
                end
                if (last_wait_s) begin
                    resp_pnum_next_s = imem_pnum;
                end else begin
                    resp_pnum_next_s = {PW{1'b0}};
                end
            end
            ST_RESP: begin
                if (pnum_r == PW'(pNUM_PORTS - 1)) begin
                    rr_ptr_next_s = {PW{1'b0}};
                end else begin
                    rr_ptr_next_s = pnum_r + PW'(1);
                end
            end
            default: cnt_next_s = {CW{1'b0}};
        endcase

        wr_en_next_s = (next_state_s == ST_ISSUE);
        busy_next_s  = (next_state_s != ST_IDLE);
        if (next_state_s == ST_RESP) begin
            ack_next_s = port_onehot(pnum_r);
        end else begin
            ack_next_s = {pNUM_PORTS{1'b0}};
        end
    end

    // Datapath and output registers.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            rr_ptr_r    <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            wr_en_r     <= 1'b0;
            pnum_r      <= {PW{1'b0}};
            sa_r        <= {pADDR_WIDTH{1'b0}};
            da_r        <= {pADDR_WIDTH{1'b0}};
            ack_r       <= {pNUM_PORTS{1'b0}};
            resp_pnum_r <= {PW{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            rr_ptr_r    <= rr_ptr_next_s;
            cnt_r       <= cnt_next_s;
            wr_en_r     <= wr_en_next_s;
            pnum_r      <= pnum_next_s;
            sa_r        <= sa_next_s;
            da_r        <= da_next_s;
            ack_r       <= ack_next_s;
            resp_pnum_r <= resp_pnum_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign omem_wr_en = wr_en_r;
    assign omem_pnum  = pnum_r;
    assign omem_sa    = sa_r;
    assign omem_da    = da_r;
    assign oack       = ack_r;
    assign oresp_pnum = resp_pnum_r;
    assign obusy      = busy_r;

    mac_lkup_arb_chk #(
        .pNUM_PORTS(pNUM_PORTS)
    ) u_chk (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .oack       (ack_r),
        .omem_wr_en (wr_en_r),
        .obusy      (busy_r)
    );

endmodule

// File: tb/tb_mac_lkup_arb.sv
// Directed self-checking bench for mac_lkup_arb with default parameters
// (4 ports, 14-bit addresses, read latency 2).

module tb_mac_lkup_arb;

    logic        iclk;
    logic        irst_n;
    logic [3:0]  ireq;
    logic [55:0] isa_bus;
    logic [55:0] ida_bus;
    logic        iage_busy;
    logic [1:0]  imem_pnum;
    logic        omem_wr_en;
    logic [1:0]  omem_pnum;
    logic [13:0] omem_sa;
    logic [13:0] omem_da;
    logic [3:0]  oack;
    logic [1:0]  oresp_pnum;
    logic        obusy;

    int checks;
    int failures;

    mac_lkup_arb dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ireq       (ireq),
        .isa_bus    (isa_bus),
        .ida_bus    (ida_bus),
        .iage_busy  (iage_busy),
        .imem_pnum  (imem_pnum),
        .omem_wr_en (omem_wr_en),
        .omem_pnum  (omem_pnum),
        .omem_sa    (omem_sa),
        .omem_da    (omem_da),
        .oack       (oack),
        .oresp_pnum (oresp_pnum),
        .obusy      (obusy)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Port 0 uses the addresses from the single-request scenario.
    function automatic logic [13:0] exp_sa(input int p);
        return (p == 0) ? 14'h0012 : (14'h1000 + 14'(p));
    endfunction

    function automatic logic [13:0] exp_da(input int p);
        return (p == 0) ? 14'h0034 : (14'h2000 + 14'(p));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"},   {31'd0, omem_wr_en}, 32'd0);
        chk({tag, "_pnum"}, {30'd0, omem_pnum},  32'd0);
        chk({tag, "_sa"},   {18'd0, omem_sa},    32'd0);
        chk({tag, "_da"},   {18'd0, omem_da},    32'd0);
        chk({tag, "_ack"},  {28'd0, oack},       32'd0);
        chk({tag, "_resp"}, {30'd0, oresp_pnum}, 32'd0);
        chk({tag, "_busy"}, {31'd0, obusy},      32'd0);
    endtask

    // One full transaction starting in IDLE: grant edge, ISSUE, 2x WAIT, RESP, IDLE.
    task automatic txn(input logic [3:0] req, input int port, input logic [1:0] pnum,
                       input string tag);
        logic [3:0] exp_ack;
        exp_ack   = 4'b0001 << port;
        ireq      = req;
        imem_pnum = pnum;
        tick();
        chk({tag, "_issue_wr"},   {31'd0, omem_wr_en}, 32'd1);
        chk({tag, "_issue_pnum"}, {30'd0, omem_pnum},  32'(port));
        chk({tag, "_issue_sa"},   {18'd0, omem_sa},    {18'd0, exp_sa(port)});
        chk({tag, "_issue_da"},   {18'd0, omem_da},    {18'd0, exp_da(port)});
        chk({tag, "_issue_busy"}, {31'd0, obusy},      32'd1);
        chk({tag, "_issue_ack"},  {28'd0, oack},       32'd0);
        tick();
        chk({tag, "_wait1_wr"},   {31'd0, omem_wr_en}, 32'd0);
        chk({tag, "_wait1_ack"},  {28'd0, oack},       32'd0);
        tick();
        chk({tag, "_wait2_ack"},  {28'd0, oack},       32'd0);
        chk({tag, "_wait2_busy"}, {31'd0, obusy},      32'd1);
        tick();
        chk({tag, "_resp_ack"},   {28'd0, oack},       {28'd0, exp_ack});
        chk({tag, "_resp_pnum"},  {30'd0, oresp_pnum}, {30'd0, pnum});
        chk({tag, "_resp_wr"},    {31'd0, omem_wr_en}, 32'd0);
        tick();
        chk({tag, "_idle_busy"},  {31'd0, obusy},      32'd0);
        chk({tag, "_idle_ack"},   {28'd0, oack},       32'd0);
        chk({tag, "_idle_sa"},    {18'd0, omem_sa},    {18'd0, exp_sa(port)});
        chk({tag, "_idle_pnum"},  {30'd0, omem_pnum},  32'(port));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        irst_n    = 1'b0;
        ireq      = 4'b0000;
        iage_busy = 1'b0;
        imem_pnum = 2'd0;
        isa_bus   = 56'd0;
        ida_bus   = 56'd0;
        for (int p = 0; p < 4; p++) begin
            isa_bus[p*14 +: 14] = exp_sa(p);
            ida_bus[p*14 +: 14] = exp_da(p);
        end

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        irst_n = 1'b1;
        tick();
        chk_all_zero("post_reset_idle");

        // Single request from port 0
        txn(4'b0001, 0, 2'd2, "single");
        ireq = 4'b0000;
        tick();
        chk("single_stay_idle_wr",   {31'd0, omem_wr_en}, 32'd0);
        chk("single_stay_idle_busy", {31'd0, obusy},      32'd0);

        // Reset returns rr_ptr to 0, then all ports request continuously
        irst_n = 1'b0;
        tick();
        irst_n = 1'b1;
        txn(4'b1111, 0, 2'd1, "all_p0");
        txn(4'b1111, 1, 2'd2, "all_p1");
        txn(4'b1111, 2, 2'd3, "all_p2");
        txn(4'b1111, 3, 2'd0, "all_p3");
        txn(4'b1111, 0, 2'd1, "all_p0b");

        // Bring rr_ptr to 3, then ports 3 and 0 request together
        txn(4'b0100, 2, 2'd0, "ptr_setup");
        txn(4'b1001, 3, 2'd1, "wrap_p3");
        txn(4'b1001, 0, 2'd2, "wrap_p0");

        // Aging sweep blocks a new grant
        ireq      = 4'b0010;
        iage_busy = 1'b1;
        tick();
        chk("age_block1_wr",   {31'd0, omem_wr_en}, 32'd0);
        chk("age_block1_busy", {31'd0, obusy},      32'd0);
        tick();
        tick();
        chk("age_block3_wr",   {31'd0, omem_wr_en}, 32'd0);
        chk("age_block3_busy", {31'd0, obusy},      32'd0);
        iage_busy = 1'b0;
        txn(4'b0010, 1, 2'd3, "age_release");

        // Aging sweep starting mid-transaction lets it finish
        ireq      = 4'b0100;
        imem_pnum = 2'd1;
        tick();
        chk("age_mid_issue_wr",   {31'd0, omem_wr_en}, 32'd1);
        chk("age_mid_issue_pnum", {30'd0, omem_pnum},  32'd2);
        tick();
        iage_busy = 1'b1;
        tick();
        tick();
        chk("age_mid_resp_ack",  {28'd0, oack},       32'h4);
        chk("age_mid_resp_pnum", {30'd0, oresp_pnum}, 32'd1);
        tick();
        chk("age_mid_idle_busy", {31'd0, obusy},      32'd0);
        tick();
        tick();
        chk("age_mid_hold_wr",   {31'd0, omem_wr_en}, 32'd0);
        chk("age_mid_hold_busy", {31'd0, obusy},      32'd0);
        iage_busy = 1'b0;
        txn(4'b0100, 2, 2'd3, "age_mid_next");

        // Asynchronous reset during WAIT aborts with no ack
        ireq      = 4'b0001;
        imem_pnum = 2'd3;
        tick();
        chk("abort_issue_wr",   {31'd0, omem_wr_en}, 32'd1);
        chk("abort_issue_pnum", {30'd0, omem_pnum},  32'd0);
        tick();
        chk("abort_wait_busy",  {31'd0, obusy},      32'd1);
        #2;
        irst_n = 1'b0;
        #1;
        chk_all_zero("abort_async");
        tick();
        tick();
        chk("abort_held_ack",  {28'd0, oack},  32'd0);
        chk("abort_held_busy", {31'd0, obusy}, 32'd0);
        irst_n = 1'b1;
        txn(4'b0100, 2, 2'd1, "after_abort");
        ireq = 4'b0000;
        tick();
        chk("final_idle_busy", {31'd0, obusy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
